// File: rtl/dot_product_stream_accel_pkg.sv
// Shared types and helpers for the streaming dot-product accelerator.
//   state_t   : controller states
//   mode_t    : per-command mode bits captured with start
//   sat_limit : saturation bound for a given signedness/direction/width
package dot_accel_pkg;

   // Widest accumulator the saturation helper can describe.
   localparam int unsigned LIMIT_W = 256;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   typedef struct packed {
      logic is_signed;
      logic accumulate;
      logic sat_en;
   } mode_t;

   // Largest (positive=1) or smallest (positive=0) value representable in
   // 'width' bits. Callers truncate the result to their own width.
   function automatic logic [LIMIT_W-1:0] sat_limit(input logic is_signed,
                                                    input logic positive,
                                                    input int unsigned width);
      logic [LIMIT_W-1:0] lim;
      lim = '0;
      for (int unsigned i = 0; i < LIMIT_W; i++) begin
         if (i < width) begin
            if (is_signed && (i == width - 1))
               lim[i] = ~positive;
            else
               lim[i] = positive;
         end
      end
      return lim;
   endfunction

endpackage

// File: rtl/dot_product_stream_accel_if.sv
// Operand and result streams of the dot-product accelerator.
//   in_valid/in_ready/a/b             : operand-pair handshake
//   res_valid/res_ready/result/ovf    : result handshake
// slave  = accelerator side, master = producer/consumer side.
interface dot_product_stream_accel_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ACC_W  = 64
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic              res_valid;
   logic              res_ready;
   logic [ACC_W-1:0]  result;
   logic              ovf;

   modport slave (
      input  in_valid, a, b, res_ready,
      output in_ready, res_valid, result, ovf
   );

   modport master (
      output in_valid, a, b, res_ready,
      input  in_ready, res_valid, result, ovf
   );
endinterface

// File: rtl/dot_product_stream_accel_mac_stage.sv
// Two-stage multiply-accumulate datapath.
//   clk, rst  : clock, synchronous active-high reset
//   load      : command accepted; captures mode, clears ovf, clears acc
//               unless cmd.accumulate
//   cmd       : mode bits presented with the command
//   fire      : operand pair transferred this cycle
//   a, b      : operands
//   acc, ovf  : accumulator and sticky overflow flag
module dot_mac_stage
   import dot_accel_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ACC_W  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  mode_t             cmd,
   input  logic              fire,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [ACC_W-1:0]  acc,
   output logic              ovf
);
   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam int unsigned EXT_W  = ACC_W + 1;

   logic              is_signed_q;
   logic              sat_en_q;
   logic [PROD_W-1:0] a_ext, b_ext, prod_now, prod_q;
   logic              prod_vld;
   logic [EXT_W-1:0]  prod_ext, acc_ext, sum;
   logic              sum_ovf, sum_pos;
   logic [ACC_W-1:0]  acc_lim, acc_next;

   // Low 2*DATA_W bits of the product of extended operands equal the exact
   // signed or unsigned product, so one multiplier serves both modes.
   always_comb begin
      a_ext = is_signed_q ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
      b_ext = is_signed_q ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
      prod_now = a_ext * b_ext;
   end

   // One guard bit above ACC_W: signed overflow shows as the top two sum
   // bits disagreeing; unsigned overflow as a carry into the guard bit.
   always_comb begin
      prod_ext = is_signed_q ? {{(EXT_W-PROD_W){prod_q[PROD_W-1]}}, prod_q}
                             : {{(EXT_W-PROD_W){1'b0}}, prod_q};
      acc_ext  = is_signed_q ? {acc[ACC_W-1], acc} : {1'b0, acc};
      sum      = acc_ext + prod_ext;
      if (is_signed_q) begin
         sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
         sum_pos = ~sum[ACC_W];
      end else begin
         sum_ovf = sum[ACC_W];
         sum_pos = 1'b1;
      end
      acc_lim  = ACC_W'(sat_limit(is_signed_q, sum_pos, ACC_W));
      acc_next = (sum_ovf && sat_en_q) ? acc_lim : sum[ACC_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         is_signed_q <= 1'b0;
         sat_en_q    <= 1'b0;
         prod_q      <= '0;
         prod_vld    <= 1'b0;
         acc         <= '0;
         ovf         <= 1'b0;
      end else begin
         prod_vld <= fire;
         if (fire)
            prod_q <= prod_now;
         if (load) begin
            is_signed_q <= cmd.is_signed;
            sat_en_q    <= cmd.sat_en;
            ovf         <= 1'b0;
            if (!cmd.accumulate)
               acc <= '0;
         end else if (prod_vld) begin
            acc <= acc_next;
            if (sum_ovf)
               ovf <= 1'b1;
         end
      end
   end
endmodule

// File: rtl/dot_product_stream_accel.sv
// Streaming dot-product accelerator: controller, length counter, handshakes.
//   clk, rst                         : clock, synchronous active-high reset
//   start, len                       : command strobe and vector length
//   is_signed, accumulate, sat_en    : command mode bits
//   busy                             : high outside IDLE
//   bus (slave)                      : operand and result streams
module dot_product_stream_accel
   import dot_accel_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MAX_LEN = 64,
   parameter int unsigned ACC_W   = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [$clog2(MAX_LEN+1)-1:0] len,
   input  logic                         is_signed,
   input  logic                         accumulate,
   input  logic                         sat_en,
   output logic                         busy,
   dot_product_stream_accel_if.slave    bus
);
   localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load, fire;
   mode_t            cmd;
   logic [ACC_W-1:0] acc;
   logic             ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      fire    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               cnt_d   = len;
               state_d = (len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (bus.in_valid) begin
               fire  = 1'b1;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1))
                  state_d = DRAIN;
            end
         end
         DRAIN: state_d = DONE;
         DONE: begin
            if (bus.res_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cmd.is_signed  = is_signed;
      cmd.accumulate = accumulate;
      cmd.sat_en     = sat_en;
      busy           = (state_q != IDLE);
      bus.in_ready   = (state_q == RUN);
      bus.res_valid  = (state_q == DONE);
      bus.result     = acc;
      bus.ovf        = ovf;
   end

   dot_mac_stage #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .cmd  (cmd),
      .fire (fire),
      .a    (bus.a),
      .b    (bus.b),
      .acc  (acc),
      .ovf  (ovf)
   );
endmodule

// File: tb/tb_dot_product_stream_accel.sv
// Directed self-checking bench for dot_product_stream_accel.
module tb_dot_product_stream_accel;
   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [6:0] len;
   logic       is_signed;
   logic       accumulate;
   logic       sat_en;
   logic       busy;
   int         checks   = 0;
   int         failures = 0;
   int unsigned lat;

   dot_product_stream_accel_if #(.DATA_W(32), .ACC_W(64)) bus ();

   dot_product_stream_accel #(
      .DATA_W  (32),
      .MAX_LEN (64),
      .ACC_W   (64)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .len        (len),
      .is_signed  (is_signed),
      .accumulate (accumulate),
      .sat_en     (sat_en),
      .busy       (busy),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic command(input logic [6:0] l, input logic sgn, input logic acc_m, input logic sat);
      start = 1'b1; len = l; is_signed = sgn; accumulate = acc_m; sat_en = sat;
      step();
      start = 1'b0;
   endtask

   task automatic send(input logic [31:0] va, input logic [31:0] vb);
      bus.a = va; bus.b = vb; bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
   endtask

   // lat counts the final transfer cycle as 1.
   task automatic wait_result(output int unsigned l);
      l = 1;
      while (!bus.res_valid && l < 20) begin
         step();
         l++;
      end
   endtask

   task automatic accept(input string tag);
      bus.res_ready = 1'b1;
      step();
      bus.res_ready = 1'b0;
      check({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; len = '0; is_signed = 1'b0; accumulate = 1'b0; sat_en = 1'b0;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.res_ready = 1'b0;
      step(); step();
      rst = 1'b0;
      check("rst_busy",      {63'd0, busy},          64'd0);
      check("rst_in_ready",  {63'd0, bus.in_ready},  64'd0);
      check("rst_res_valid", {63'd0, bus.res_valid}, 64'd0);
      check("rst_result",    bus.result,             64'd0);
      check("rst_ovf",       {63'd0, bus.ovf},       64'd0);

      // len=8 signed, 1..8 squared
      command(7'd8, 1'b1, 1'b0, 1'b1);
      check("dot8_busy",     {63'd0, busy},         64'd1);
      check("dot8_in_ready", {63'd0, bus.in_ready}, 64'd1);
      for (int i = 1; i <= 8; i++) send(32'(i), 32'(i));
      check("dot8_drain_in_ready", {63'd0, bus.in_ready}, 64'd0);
      wait_result(lat);
      check("dot8_latency", 64'(lat),          64'd2);
      check("dot8_result",  bus.result,        64'd204);
      check("dot8_ovf",     {63'd0, bus.ovf},  64'd0);
      accept("dot8");

      // signed saturation
      command(7'd4, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) send(32'h8000_0000, 32'h8000_0000);
      wait_result(lat);
      check("sat_result", bus.result,       64'h7FFF_FFFF_FFFF_FFFF);
      check("sat_ovf",    {63'd0, bus.ovf}, 64'd1);
      accept("sat");

      // signed wrap
      command(7'd4, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send(32'h8000_0000, 32'h8000_0000);
      wait_result(lat);
      check("wrap_result", bus.result,       64'd0);
      check("wrap_ovf",    {63'd0, bus.ovf}, 64'd1);
      accept("wrap");

      // unsigned with in_valid gaps
      command(7'd3, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
         if (i < 2) step();
      end
      wait_result(lat);
      check("gap_latency", 64'(lat),         64'd2);
      check("gap_result",  bus.result,       64'hFFFF_FFFA_0000_0003);
      check("gap_ovf",     {63'd0, bus.ovf}, 64'd1);
      accept("gap");

      // accumulate chain
      command(7'd2, 1'b1, 1'b0, 1'b0);
      send(32'd3, 32'd4);
      send(32'd5, 32'd6);
      wait_result(lat);
      check("chain1_result", bus.result, 64'd42);
      accept("chain1");
      command(7'd1, 1'b1, 1'b1, 1'b0);
      send(32'hFFFF_FFFE, 32'd10);
      wait_result(lat);
      check("chain2_result", bus.result,       64'd22);
      check("chain2_ovf",    {63'd0, bus.ovf}, 64'd0);
      accept("chain2");
      command(7'd0, 1'b1, 1'b1, 1'b0);
      check("len0_res_valid", {63'd0, bus.res_valid}, 64'd1);
      check("len0_result",    bus.result,             64'd22);
      check("len0_ovf",       {63'd0, bus.ovf},       64'd0);
      accept("len0");

      // reset mid-run, with start and in_valid also high
      command(7'd8, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) send(32'd100, 32'd100);
      rst = 1'b1; start = 1'b1; bus.in_valid = 1'b1;
      step();
      rst = 1'b0; start = 1'b0; bus.in_valid = 1'b0;
      check("midrst_busy",      {63'd0, busy},          64'd0);
      check("midrst_in_ready",  {63'd0, bus.in_ready},  64'd0);
      check("midrst_res_valid", {63'd0, bus.res_valid}, 64'd0);
      check("midrst_result",    bus.result,             64'd0);
      check("midrst_ovf",       {63'd0, bus.ovf},       64'd0);
      // accumulate=1 shows the accumulator really was cleared by reset
      command(7'd2, 1'b1, 1'b1, 1'b0);
      send(32'd7, 32'd3);
      send(32'd2, 32'd5);
      wait_result(lat);
      check("postrst_result", bus.result, 64'd31);
      accept("postrst");

      // DONE held with res_ready low; start and in_valid ignored
      command(7'd1, 1'b0, 1'b0, 1'b0);
      send(32'd6, 32'd7);
      wait_result(lat);
      for (int i = 0; i < 5; i++) begin
         start = (i == 1); len = 7'd3; accumulate = 1'b0;
         bus.in_valid = 1'b1; bus.a = 32'd100; bus.b = 32'd100;
         step();
         check("hold_res_valid", {63'd0, bus.res_valid}, 64'd1);
         check("hold_result",    bus.result,             64'd42);
         check("hold_in_ready",  {63'd0, bus.in_ready},  64'd0);
      end
      start = 1'b0; bus.in_valid = 1'b0;
      accept("hold");
      step();
      check("hold_stays_idle", {63'd0, busy}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
